tex_req_arb: RTL and testbench
==============================

TEX_REQ_ARB -- requirements
Module: tex_req_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of texture requesters (cores/issue slots) sharing one texture unit.
REQ-002 SHALL have parameter REQ_DATAW, default 128, request payload width (unit, coords, lod, wid, tmask, PC, rd, wb).
REQ-003 SHALL have parameter RSP_DATAW, default 128, response payload width.
REQ-004 SHALL have parameter TAG_WIDTH, default 4, per-requester tag width.
REQ-005 SHALL have parameter MAX_PENDING, default 8, maximum outstanding requests at the texture unit; range 1..255.
REQ-006 SHALL have localparam SELW = max(1, clog2(NUM_REQS)) and OTAGW = TAG_WIDTH + SELW.
REQ-007 clk  input  1  single clock; all state rising-edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 req_valid  input  NUM_REQS  per-requester request valid.
REQ-010 req_data  input  NUM_REQS*REQ_DATAW  request payloads, requester i at slice i.
REQ-011 req_tag  input  NUM_REQS*TAG_WIDTH  request tags.
REQ-012 req_ready  output  NUM_REQS  per-requester accept.
REQ-013 tex_req_valid / tex_req_data / tex_req_tag  output  1 / REQ_DATAW / OTAGW  request to texture unit; tag = {requester index, requester tag}.
REQ-014 tex_req_ready  input  1  texture unit accept.
REQ-015 tex_rsp_valid / tex_rsp_data / tex_rsp_tag  input  1 / RSP_DATAW / OTAGW  response from texture unit.
REQ-016 tex_rsp_ready  output  1  response accept.
REQ-017 rsp_valid  output  NUM_REQS  one-hot routed response valid.
REQ-018 rsp_data / rsp_tag  output  RSP_DATAW / TAG_WIDTH  response payload and stripped tag, shared by all requesters.
REQ-019 rsp_ready  input  NUM_REQS  per-requester response accept.
REQ-020 pending  output  8  outstanding request count.

Function
REQ-021 Request path SHALL be a single registered output stage; stage "free" = !tex_req_valid || tex_req_ready.
REQ-022 Issue allowed SHALL mean stage free AND (pending + out-stage-occupancy-after-pop) < MAX_PENDING; count includes the request being loaded.
REQ-023 When issue allowed, SHALL grant exactly one valid requester by round-robin, searching from (last_grant+1) mod NUM_REQS upward with wrap.
REQ-024 req_ready SHALL be one-hot on the granted requester in the grant cycle, all zero otherwise; no combinational path from tex_req_ready to req_ready other than via stage-free.
REQ-025 On grant, SHALL load stage next cycle edge: tex_req_valid=1, data/tag from granted requester; last_grant updated to winner.
REQ-026 While tex_req_valid && !tex_req_ready, tex_req_data/tag SHALL hold stable.
REQ-027 pending SHALL increment on tex_req_valid && tex_req_ready, decrement on tex_rsp_valid && tex_rsp_ready; both same cycle -> unchanged; never wraps.
REQ-028 Response path SHALL be combinational: rsp_valid[i] = tex_rsp_valid && (tex_rsp_tag[OTAGW-1:TAG_WIDTH] == i); rsp_data = tex_rsp_data; rsp_tag = low TAG_WIDTH bits.
REQ-029 tex_rsp_ready SHALL equal rsp_ready[selected index]; index >= NUM_REQS -> tex_rsp_ready=1, response dropped, no rsp_valid.
REQ-030 Latency: requester handshake to tex_req_valid SHALL be exactly 1 cycle; back-to-back issue at 1 request/cycle when tex_req_ready held high.
REQ-031 NUM_REQS=1 SHALL degenerate to a registered pass-through with index bit constant 0.
REQ-032 Response arriving with pending==0 SHALL be routed but pending stays 0 (saturate).

Reset
REQ-033 reset low SHALL immediately force tex_req_valid=0, pending=0, last_grant=NUM_REQS-1 (first search starts at 0); req_ready=0 while in reset.
REQ-034 Reset mid-transfer SHALL discard the staged request; no replay after reset release.

Verification
REQ-035 All 4 requesters valid continuously, tex_req_ready=1, texture unit responds immediately -> grants 0,1,2,3,0,... one per cycle, tags 0x?,0x1?,0x2?,0x3? in index field.
REQ-036 MAX_PENDING=8, no responses -> exactly 8 requests issued, then req_ready all 0; one response -> exactly one more issued.
REQ-037 tex_req_ready low 5 cycles with staged request from requester 2 -> tex_req_data/tag stable, no req_ready asserted; accept on release.
REQ-038 Response tag {2'd3,4'hA} with rsp_ready[3]=0 -> rsp_valid=4'b1000, rsp_tag=4'hA, tex_rsp_ready=0 until rsp_ready[3]=1.
REQ-039 Simultaneous issue and response at pending=5 -> pending stays 5.
REQ-040 reset pulsed low while tex_req_valid=1 and pending=3 -> tex_req_valid=0, pending=0 asynchronously; first grant after release goes to requester 0.

Source files
------------

// File: rtl/tex_req_arb.sv
// Round-robin arbiter funnelling NUM_REQS texture requesters into one texture unit, with a
// registered request stage, an outstanding-request limit and tag-routed responses.
module tex_req_arb #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned REQ_DATAW   = 128,
    parameter int unsigned RSP_DATAW   = 128,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned MAX_PENDING = 8,
    localparam int unsigned SELW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned OTAGW      = TAG_WIDTH + SELW
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
    output logic [NUM_REQS-1:0]           req_ready,

    output logic                          tex_req_valid,
    output logic [REQ_DATAW-1:0]          tex_req_data,
    output logic [OTAGW-1:0]              tex_req_tag,
    input  logic                          tex_req_ready,

    input  logic                          tex_rsp_valid,
    input  logic [RSP_DATAW-1:0]          tex_rsp_data,
    input  logic [OTAGW-1:0]              tex_rsp_tag,
    output logic                          tex_rsp_ready,

    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [RSP_DATAW-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    input  logic [NUM_REQS-1:0]           rsp_ready,

    output logic [7:0]                    pending
);

    logic                 valid_q;
    logic [REQ_DATAW-1:0] data_q;
    logic [OTAGW-1:0]     tag_q;
    logic [SELW-1:0]      last_q;
    logic [7:0]           pending_q, pending_d;
    logic                 run_q;

    logic                 stage_free;
    logic [8:0]           load_cnt;
    logic                 issue_ok;
    logic                 grant_any;
    logic [SELW-1:0]      grant;
    logic                 fire_req, fire_rsp;
    logic [SELW-1:0]      rsp_sel;

    assign stage_free = !valid_q || tex_req_ready;
    // A staged request either stays staged or moves into pending, so it always counts once.
    assign load_cnt   = {1'b0, pending_q} + {8'd0, valid_q};
    assign issue_ok   = run_q && stage_free && (load_cnt < 9'(MAX_PENDING));

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = last_q;
        grant_any = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQS; k++) begin
            idx = (32'(last_q) + k) % NUM_REQS;
            if (!grant_any && req_valid[idx]) begin
                grant     = SELW'(idx);
                grant_any = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = issue_ok && grant_any && (grant == SELW'(i));
        end
    end

    assign fire_req = valid_q && tex_req_ready;
    assign fire_rsp = tex_rsp_valid && tex_rsp_ready;

    always_comb begin
        pending_d = pending_q;
        if (fire_req && !fire_rsp && (pending_q != 8'hFF)) begin
            pending_d = pending_q + 8'd1;
        end else if (!fire_req && fire_rsp && (pending_q != 8'd0)) begin
            pending_d = pending_q - 8'd1;
        end
    end

    // run_q keeps req_ready low throughout reset without a combinational path from reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
            last_q    <= SELW'(NUM_REQS - 1);
            pending_q <= 8'd0;
            run_q     <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            pending_q <= pending_d;
            if (stage_free) begin
                valid_q <= issue_ok && grant_any;
            end
            if (issue_ok && grant_any) begin
                data_q <= req_data[grant*REQ_DATAW +: REQ_DATAW];
                tag_q  <= {grant, req_tag[grant*TAG_WIDTH +: TAG_WIDTH]};
                last_q <= grant;
            end
        end
    end

    assign tex_req_valid = valid_q;
    assign tex_req_data  = data_q;
    assign tex_req_tag   = tag_q;
    assign pending       = pending_q;

    assign rsp_sel  = tex_rsp_tag[OTAGW-1:TAG_WIDTH];
    assign rsp_data = tex_rsp_data;
    assign rsp_tag  = tex_rsp_tag[TAG_WIDTH-1:0];

    // An index with no matching requester matches nothing below and is accepted and dropped.
    always_comb begin
        rsp_valid     = '0;
        tex_rsp_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (rsp_sel == SELW'(i)) begin
                rsp_valid[i]  = tex_rsp_valid;
                tex_rsp_ready = rsp_ready[i];
            end
        end
    end

endmodule

// File: tb/tb_tex_req_arb.sv
// Scoreboard bench for tex_req_arb: expected issues and responses are queued as stimulus is
// driven and popped by negedge monitors when the DUT hands them off.
module tb_tex_req_arb;

    localparam int NR  = 4;
    localparam int DW  = 128;
    localparam int TW  = 4;
    localparam int OTW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR*TW-1:0]  req_tag;
    logic [NR-1:0]     req_ready;
    logic              tex_req_valid;
    logic [DW-1:0]     tex_req_data;
    logic [OTW-1:0]    tex_req_tag;
    logic              tex_req_ready;
    logic              tex_rsp_valid;
    logic [DW-1:0]     tex_rsp_data;
    logic [OTW-1:0]    tex_rsp_tag;
    logic              tex_rsp_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic [NR-1:0]     rsp_ready;
    logic [7:0]        pending;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [OTW-1:0] exp_tag_q[$];
    logic [DW-1:0]  exp_data_q[$];
    logic [NR-1:0]  exp_rv_q[$];
    logic [TW-1:0]  exp_rt_q[$];
    logic [DW-1:0]  exp_rd_q[$];

    tex_req_arb dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .tex_req_valid (tex_req_valid),
        .tex_req_data  (tex_req_data),
        .tex_req_tag   (tex_req_tag),
        .tex_req_ready (tex_req_ready),
        .tex_rsp_valid (tex_rsp_valid),
        .tex_rsp_data  (tex_rsp_data),
        .tex_rsp_tag   (tex_rsp_tag),
        .tex_rsp_ready (tex_rsp_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_ready     (rsp_ready),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tag_of(input int i);
        return TW'(i + 5);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(32'hCAFE_0000 + i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_issue(input int i);
        exp_tag_q.push_back({2'(i), tag_of(i)});
        exp_data_q.push_back(data_of(i));
    endtask

    task automatic drive_rsp(input int idx, input logic [TW-1:0] t, input logic [31:0] d);
        tex_rsp_valid = 1'b1;
        tex_rsp_tag   = {2'(idx), t};
        tex_rsp_data  = DW'(d);
        exp_rv_q.push_back(NR'(1 << idx));
        exp_rt_q.push_back(t);
        exp_rd_q.push_back(DW'(d));
    endtask

    task automatic send_rsp(input int idx, input logic [TW-1:0] t, input logic [31:0] d);
        tick();
        drive_rsp(idx, t, d);
        tick();
        tex_rsp_valid = 1'b0;
    endtask

    // Issue monitor: every handoff to the texture unit must match the next queued expectation.
    always @(negedge clk) begin
        if (reset && tex_req_valid && tex_req_ready) begin
            if (exp_tag_q.size() == 0) begin
                check_eq("unexpected_issue", tex_req_tag, '1);
            end else begin
                check_eq("issue_tag", tex_req_tag, exp_tag_q.pop_front());
                check_eq("issue_data", tex_req_data, exp_data_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && tex_rsp_valid && tex_rsp_ready) begin
            if (exp_rv_q.size() == 0) begin
                check_eq("unexpected_rsp", rsp_valid, '1);
            end else begin
                check_eq("rsp_valid", rsp_valid, exp_rv_q.pop_front());
                check_eq("rsp_tag", rsp_tag, exp_rt_q.pop_front());
                check_eq("rsp_data", rsp_data, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        logic [OTW-1:0] stall_tag;
        reset         = 1'b0;
        req_valid     = '1;
        tex_req_ready = 1'b0;
        tex_rsp_valid = 1'b0;
        tex_rsp_data  = '0;
        tex_rsp_tag   = '0;
        rsp_ready     = '1;
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = data_of(i);
            req_tag[i*TW +: TW]  = tag_of(i);
        end

        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, '0);
        check_eq("rst_tex_valid", tex_req_valid, 0);
        check_eq("rst_pending", pending, 0);
        tick();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        tick();

        // Round-robin, back-to-back, capped at MAX_PENDING with no responses.
        tex_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_issue(k % NR);
        req_valid = '1;
        @(negedge clk);
        check_eq("first_grant", req_ready, 4'b0001);
        @(negedge clk);
        check_eq("one_cycle_latency", tex_req_valid, 1);
        check_eq("second_grant", req_ready, 4'b0010);
        repeat (12) tick();
        @(negedge clk);
        check_eq("cap_ready", req_ready, '0);
        check_eq("cap_pending", pending, 8);
        check_eq("cap_issued", exp_tag_q.size(), 0);

        // One response frees exactly one slot.
        push_issue(0);
        send_rsp(0, 4'h7, 32'hBEEF_0000);
        repeat (4) tick();
        @(negedge clk);
        check_eq("refill_ready", req_ready, '0);
        check_eq("refill_pending", pending, 8);
        check_eq("refill_issued", exp_tag_q.size(), 0);

        tick();
        req_valid = '0;
        for (int k = 0; k < 8; k++) send_rsp(k % NR, TW'(k), 32'hBEEF_0100 + k);
        tick();
        @(negedge clk);
        check_eq("drain_pending", pending, 0);

        // Stalled stage holds its contents and blocks further grants.
        tick();
        tex_req_ready = 1'b0;
        req_valid     = 4'b0100;
        stall_tag     = {2'd2, tag_of(2)};
        push_issue(2);
        @(negedge clk);
        check_eq("stall_grant", req_ready, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check_eq("stall_valid", tex_req_valid, 1);
            check_eq("stall_tag", tex_req_tag, stall_tag);
            check_eq("stall_data", tex_req_data, data_of(2));
            check_eq("stall_no_ready", req_ready, '0);
        end
        tick();
        tex_req_ready = 1'b1;
        req_valid     = '0;
        tick();
        @(negedge clk);
        check_eq("stall_pending", pending, 1);
        check_eq("stall_issued", exp_tag_q.size(), 0);

        // Build pending to 5, then issue and respond in the same cycle.
        tick();
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) push_issue(1);
        repeat (4) tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check_eq("pre_sim_pending", pending, 5);
        tick();
        req_valid = 4'b1000;
        push_issue(3);
        tick();
        req_valid = '0;
        drive_rsp(1, 4'h3, 32'hBEEF_0200);
        tick();
        tex_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("sim_pending", pending, 5);

        // Response back-pressure from requester 3.
        tick();
        tex_rsp_valid = 1'b1;
        tex_rsp_tag   = {2'd3, 4'hA};
        tex_rsp_data  = DW'(32'hBEEF_0300);
        rsp_ready     = 4'b0111;
        @(negedge clk);
        check_eq("bp_rsp_valid", rsp_valid, 4'b1000);
        check_eq("bp_rsp_tag", rsp_tag, 4'hA);
        check_eq("bp_ready_low", tex_rsp_ready, 0);
        tick();
        @(negedge clk);
        check_eq("bp_ready_still_low", tex_rsp_ready, 0);
        check_eq("bp_pending", pending, 5);
        tick();
        rsp_ready = '1;
        exp_rv_q.push_back(4'b1000);
        exp_rt_q.push_back(4'hA);
        exp_rd_q.push_back(DW'(32'hBEEF_0300));
        @(negedge clk);
        check_eq("bp_ready_high", tex_rsp_ready, 1);
        tick();
        tex_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_pending_dec", pending, 4);

        // Asynchronous reset with a staged request and pending=3.
        send_rsp(2, 4'h1, 32'hBEEF_0400);
        tick();
        tex_req_ready = 1'b0;
        req_valid     = 4'b0010;
        tick();
        req_valid = '0;
        @(negedge clk);
        check_eq("pre_rst_valid", tex_req_valid, 1);
        check_eq("pre_rst_pending", pending, 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", tex_req_valid, 0);
        check_eq("arst_pending", pending, 0);
        tick();
        tick();
        reset         = 1'b1;
        tex_req_ready = 1'b1;
        tick();
        tick();
        push_issue(0);
        req_valid = '1;
        @(negedge clk);
        check_eq("post_rst_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("post_rst_pending", pending, 1);
        check_eq("issue_queue_empty", exp_tag_q.size(), 0);
        check_eq("rsp_queue_empty", exp_rv_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
